// File: rtl/noise_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noise_pkg
//  Description : Shared types and constants for the noise statistics monitor:
//                run-state encoding, default out-of-bounds limits derived from
//                the amplifier operating point, and min/max search sentinels.
//  Revision    : 1.0 - initial release
// ============================================================================
package noise_pkg;

  // Run-state encoding for the monitor FSM
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SKIP  = 3'd1,
    ST_ACCUM = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Amplifier operating point the default bounds are derived from
  localparam real c_gain      = 0.5;
  localparam real c_dc_in     = 10.0;
  localparam real c_noise_rms = 0.25;

  // Nominal output +/- three sigma of noise
  localparam real c_default_lower = c_gain * c_dc_in - 3.0 * c_noise_rms;
  localparam real c_default_upper = c_gain * c_dc_in + 3.0 * c_noise_rms;

  // Starting points for the running min/max search
  localparam real c_min_init = 1.0e30;
  localparam real c_max_init = -1.0e30;

endpackage : noise_pkg
`default_nettype wire

// File: rtl/noise_stats_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : noise_stats_monitor
//  Description : Samples a noisy amplifier output against its ideal value,
//                discards SKIP settling samples, accumulates WINDOW samples
//                and reports mean error, RMS error, min/max output and the
//                out-of-bounds count.
//  Revision    : 1.0 - initial release
// ============================================================================
module noise_stats_monitor
  import noise_pkg::*;
#(
  parameter int  WINDOW      = 1024,              // power of 2, >= 2
  parameter int  SKIP        = 20,                // 0 is legal
  parameter real LOWER_BOUND = c_default_lower,
  parameter real UPPER_BOUND = c_default_upper,
  parameter int  CNT_W       = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sample_valid,
  input  real              sample_in,
  input  real              ideal_in,
  output logic             busy,
  output logic             done,
  output real              mean_err,
  output real              rms_err,
  output real              min_out,
  output real              max_out,
  output logic [CNT_W-1:0] oob_count,
  output logic [CNT_W-1:0] acc_count
);

  // Skip counter needs at least one bit even when no skipping is configured
  localparam int                  c_skip_w   = (SKIP > 1) ? $clog2(SKIP + 1) : 1;
  localparam logic [c_skip_w-1:0] c_skip_last = c_skip_w'((SKIP > 0) ? SKIP - 1 : 0);
  localparam logic [c_skip_w-1:0] c_skip_one  = c_skip_w'(1);
  localparam logic [CNT_W-1:0]    c_window    = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0]    c_cnt_one   = CNT_W'(1);
  localparam real                 c_window_r  = $itor(WINDOW);

  state_e              r_state;
  state_e              w_state_next;

  logic                w_start_ok;
  logic                w_take_skip;
  logic                w_take_acc;
  logic                w_window_full;

  logic [c_skip_w-1:0] r_skip_cnt;
  logic [CNT_W-1:0]    r_acc_count;
  logic [CNT_W-1:0]    r_oob_count;
  logic                r_done;

  real                 r_sum;
  real                 r_sumsq;
  real                 r_min;
  real                 r_max;
  real                 r_mean;
  real                 r_rms;
  real                 r_min_out;
  real                 r_max_out;

  real                 w_err;
  real                 w_mean;
  real                 w_var;
  real                 w_rms;

  // A start request only counts when no run is in progress
  assign w_start_ok    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_window_full = (r_acc_count == c_window);
  assign w_take_skip   = (r_state == ST_SKIP) && sample_valid;
  // Once the window is full ACCUM lingers one cycle; no sample is taken then
  assign w_take_acc    = (r_state == ST_ACCUM) && sample_valid && !w_window_full;

  // Per-sample error and end-of-window statistics
  always_comb begin
    w_err  = sample_in - ideal_in;
    w_mean = r_sum / c_window_r;
    w_var  = r_sumsq / c_window_r - w_mean * w_mean;
    // Rounding can push a near-zero variance slightly negative
    if (w_var < 0.0) begin
      w_var = 0.0;
    end
    w_rms  = $sqrt(w_var);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_next = (SKIP == 0) ? ST_ACCUM : ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (sample_valid && (r_skip_cnt == c_skip_last)) begin
          w_state_next = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // Leave one cycle after the last sample so FINAL reads settled sums
        if (w_window_full) begin
          w_state_next = ST_FINAL;
        end
      end
      ST_FINAL: begin
        w_state_next = ST_DONE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Skip-period and accumulated-sample counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skip_cnt  <= '0;
      r_acc_count <= '0;
      r_oob_count <= '0;
    end else if (w_start_ok) begin
      r_skip_cnt  <= '0;
      r_acc_count <= '0;
      r_oob_count <= '0;
    end else begin
      if (w_take_skip) begin
        r_skip_cnt <= r_skip_cnt + c_skip_one;
      end
      if (w_take_acc) begin
        r_acc_count <= r_acc_count + c_cnt_one;
        // Strict compares: a sample sitting exactly on a bound is in range
        if ((sample_in < LOWER_BOUND) || (sample_in > UPPER_BOUND)) begin
          r_oob_count <= r_oob_count + c_cnt_one;
        end
      end
    end
  end

  // Error sums and running min/max of the accepted samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= 0.0;
      r_sumsq <= 0.0;
      r_min   <= c_min_init;
      r_max   <= c_max_init;
    end else if (w_start_ok) begin
      r_sum   <= 0.0;
      r_sumsq <= 0.0;
      r_min   <= c_min_init;
      r_max   <= c_max_init;
    end else if (w_take_acc) begin
      r_sum   <= r_sum + w_err;
      r_sumsq <= r_sumsq + w_err * w_err;
      if (sample_in < r_min) begin
        r_min <= sample_in;
      end
      if (sample_in > r_max) begin
        r_max <= sample_in;
      end
    end
  end

  // Result registers: loaded in FINAL, held through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done    <= 1'b0;
      r_mean    <= 0.0;
      r_rms     <= 0.0;
      r_min_out <= 0.0;
      r_max_out <= 0.0;
    end else if (w_start_ok) begin
      r_done <= 1'b0;
    end else if (r_state == ST_FINAL) begin
      r_done    <= 1'b1;
      r_mean    <= w_mean;
      r_rms     <= w_rms;
      r_min_out <= r_min;
      r_max_out <= r_max;
    end
  end

  assign busy      = (r_state == ST_SKIP) || (r_state == ST_ACCUM) || (r_state == ST_FINAL);
  assign done      = r_done;
  assign mean_err  = r_mean;
  assign rms_err   = r_rms;
  assign min_out   = r_min_out;
  assign max_out   = r_max_out;
  assign oob_count = r_oob_count;
  assign acc_count = r_acc_count;

endmodule : noise_stats_monitor
`default_nettype wire

// File: tb/tb_noise_stats_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noise_stats_monitor
//  Description : Self-checking bench for noise_stats_monitor. A sample-list
//                model recomputes every statistic from the raw window; a
//                compare process checks all outputs each cycle, and directed
//                runs pin literal results and latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_noise_stats_monitor;

  localparam int  W  = 1024;
  localparam int  S  = 20;
  localparam int  CW = $clog2(W + 1);
  localparam real LB = 4.25;
  localparam real UB = 5.75;

  logic          clk          = 1'b0;
  logic          rst_n        = 1'b0;
  logic          start        = 1'b0;
  logic          start0       = 1'b0;
  logic          sample_valid = 1'b0;
  real           sample_in    = 0.0;
  real           ideal_in     = 5.0;

  logic          busy, done;
  real           mean_err, rms_err, min_out, max_out;
  logic [CW-1:0] oob_count, acc_count;

  logic          busy0, done0;
  real           mean0, rms0, min0, max0;
  logic [2:0]    oob0, acc0;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  noise_stats_monitor #(.WINDOW(W), .SKIP(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .sample_in(sample_in), .ideal_in(ideal_in), .busy(busy), .done(done),
    .mean_err(mean_err), .rms_err(rms_err), .min_out(min_out), .max_out(max_out),
    .oob_count(oob_count), .acc_count(acc_count)
  );

  noise_stats_monitor #(.WINDOW(4), .SKIP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .sample_valid(sample_valid),
    .sample_in(sample_in), .ideal_in(ideal_in), .busy(busy0), .done(done0),
    .mean_err(mean0), .rms_err(rms0), .min_out(min0), .max_out(max0),
    .oob_count(oob0), .acc_count(acc0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_int(input string name, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_real(input string name, input real got, input real exp, input real tol);
    n_vec++;
    if ((got - exp > tol) || (exp - got > tol)) begin
      n_bad++;
      $display("FAIL %s got=%g exp=%g (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Tracks a run as a list of accepted samples; statistics are computed from
  // the complete list once the window closes.
  bit  m_run, m_done;
  int  m_nv, m_wait, m_acc, m_oob;
  real m_mean, m_rms, m_min, m_max;
  real q_err[$];
  real q_smp[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0; m_done = 1'b0; m_nv = 0; m_wait = 0; m_acc = 0; m_oob = 0;
      m_mean = 0.0; m_rms = 0.0; m_min = 0.0; m_max = 0.0;
      q_err.delete(); q_smp.delete();
    end else if (m_run) begin
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          real s, v;
          s = 0.0;
          foreach (q_err[i]) s += q_err[i];
          m_mean = s / W;
          v = 0.0;
          foreach (q_err[i]) v += (q_err[i] - m_mean) * (q_err[i] - m_mean);
          m_rms = $sqrt(v / W);
          m_min = q_smp[0];
          m_max = q_smp[0];
          foreach (q_smp[i]) begin
            if (q_smp[i] < m_min) m_min = q_smp[i];
            if (q_smp[i] > m_max) m_max = q_smp[i];
          end
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end else if (sample_valid) begin
        m_nv++;
        if (m_nv > S) begin
          q_err.push_back(sample_in - ideal_in);
          q_smp.push_back(sample_in);
          m_acc++;
          if (sample_in < LB || sample_in > UB) m_oob++;
          // done follows the last window sample by two edges
          if (q_err.size() == W) m_wait = 2;
        end
      end
    end else if (start) begin
      m_run = 1'b1; m_done = 1'b0; m_nv = 0; m_wait = 0; m_acc = 0; m_oob = 0;
      q_err.delete(); q_smp.delete();
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk_int("busy", busy, m_run);
    chk_int("done", done, m_done);
    chk_int("acc_count", acc_count, m_acc);
    chk_int("oob_count", oob_count, m_oob);
    chk_real("mean_err", mean_err, m_mean, 1e-9);
    chk_real("rms_err", rms_err, m_rms, 1e-9);
    chk_real("min_out", min_out, m_min, 1e-12);
    chk_real("max_out", max_out, m_max, 1e-12);
  end

  // ------------------------------------------------------------ stimulus
  function automatic real gen(input int kind, input int idx);
    int j;
    j = idx - S;
    case (kind)
      1:       return (idx % 2 == 1) ? 5.25 : 4.75;
      2:       return (j >= 1 && j <= 3) ? 6.0 : (j == 4) ? 5.75 : (j == 5) ? 4.25 : 5.0;
      3:       return (idx <= S) ? 9.0 : 5.0;
      default: return 5.0;
    endcase
  endfunction

  // Called just after the negedge following the accepting edge
  task automatic drive_until_done(input int kind, input bit toggle, input int abort_at,
                                  input int poke_at, output int lat);
    int  c0, idx;
    bit  poked, poke_chk;
    c0 = cyc; idx = 0; lat = -1; poked = 1'b0; poke_chk = 1'b0;
    for (int k = 1; k <= 4000; k++) begin
      if (poke_chk) begin
        chk_int("start_in_accum_acc", acc_count, poke_at + 1);
        chk_int("start_in_accum_busy", busy, 1);
        poke_chk = 1'b0;
      end
      if (abort_at > 0 && acc_count == CW'(abort_at)) begin
        lat = 0;
        return;
      end
      start = 1'b0;
      if (poke_at > 0 && !poked && acc_count == CW'(poke_at)) begin
        start = 1'b1; poked = 1'b1; poke_chk = 1'b1;
      end
      sample_valid = toggle ? (k % 2 == 0) : 1'b1;
      if (sample_valid) begin
        idx++;
        sample_in = gen(kind, idx);
      end
      @(negedge clk);
      if (done) begin
        lat = cyc - c0;
        break;
      end
    end
    start = 1'b0;
    sample_valid = 1'b0;
    if (lat < 0) begin
      n_vec++; n_bad++;
      $display("FAIL done_timeout got=no_done exp=done");
    end
  endtask

  task automatic drive_run(input int kind, input bit toggle, input int abort_at,
                           input int poke_at, output int lat);
    start = 1'b1;
    // Present on the accepting edge; must never be consumed
    sample_valid = 1'b1;
    sample_in = 9.9;
    @(negedge clk);
    start = 1'b0;
    drive_until_done(kind, toggle, abort_at, poke_at, lat);
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk_int("reset_busy", busy, 0);
    chk_int("reset_done", done, 0);
    chk_int("reset_acc", acc_count, 0);
    chk_real("reset_max", max_out, 0.0, 0.0);
    rst_n = 1'b1;
    @(negedge clk);

    // Constant input
    drive_run(0, 1'b0, 0, 0, lat);
    chk_int("const_latency", lat, 1046);
    chk_real("const_mean", mean_err, 0.0, 1e-12);
    chk_real("const_rms", rms_err, 0.0, 1e-12);
    chk_real("const_min", min_out, 5.0, 0.0);
    chk_real("const_max", max_out, 5.0, 0.0);
    chk_int("const_oob", oob_count, 0);

    // Alternating +/-0.25 error
    drive_run(1, 1'b0, 0, 0, lat);
    chk_real("alt_mean", mean_err, 0.0, 1e-12);
    chk_real("alt_rms", rms_err, 0.25, 1e-9);
    chk_real("alt_min", min_out, 4.75, 0.0);
    chk_real("alt_max", max_out, 5.25, 0.0);
    chk_int("alt_oob", oob_count, 0);

    // Out-of-bounds and exact-bound samples
    drive_run(2, 1'b0, 0, 0, lat);
    chk_int("bound_oob", oob_count, 3);
    chk_real("bound_max", max_out, 6.0, 0.0);
    chk_real("bound_min", min_out, 4.25, 0.0);
    chk_real("bound_mean", mean_err, 3.0 / 1024.0, 1e-12);

    // Skip-period outliers must be invisible
    drive_run(3, 1'b0, 0, 0, lat);
    chk_real("skip_max", max_out, 5.0, 0.0);
    chk_int("skip_oob", oob_count, 0);

    // Half-rate valid
    drive_run(1, 1'b1, 0, 0, lat);
    chk_int("toggle_latency", lat, 2 * 1044 + 2);
    chk_real("toggle_rms", rms_err, 0.25, 1e-9);
    chk_real("toggle_mean", mean_err, 0.0, 1e-12);
    chk_real("toggle_min", min_out, 4.75, 0.0);

    // SKIP=0 instance: first valid sample after start is accumulated
    start0 = 1'b1; sample_valid = 1'b1; sample_in = 9.9;
    @(negedge clk);
    start0 = 1'b0;
    chk_int("skip0_start_edge_acc", acc0, 0);
    chk_int("skip0_busy", busy0, 1);
    for (int i = 0; i < 4; i++) begin
      sample_in = (i == 0) ? 7.0 : 5.0;
      @(negedge clk);
      if (i == 0) chk_int("skip0_first_counted", acc0, 1);
    end
    sample_valid = 1'b0;
    @(negedge clk);
    chk_int("skip0_done_early", done0, 0);
    @(negedge clk);
    chk_int("skip0_done", done0, 1);
    chk_real("skip0_max", max0, 7.0, 0.0);
    chk_real("skip0_min", min0, 5.0, 0.0);
    chk_int("skip0_oob", oob0, 1);
    chk_real("skip0_mean", mean0, 0.5, 1e-12);
    chk_real("skip0_rms", rms0, 0.8660254037844386, 1e-9);

    // start during ACCUM is ignored
    drive_run(0, 1'b0, 0, 100, lat);
    chk_int("poke_latency", lat, 1046);

    // start in DONE clears done on the next edge and begins a new run
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_int("restart_done_cleared", done, 0);
    chk_int("restart_busy", busy, 1);
    drive_until_done(2, 1'b0, 0, 0, lat);
    chk_int("restart_latency", lat, 1046);
    chk_int("restart_oob", oob_count, 3);

    // Reset mid-run
    drive_run(0, 1'b0, 500, 0, lat);
    #2;
    rst_n = 1'b0;
    #1;
    chk_int("midreset_busy", busy, 0);
    chk_int("midreset_done", done, 0);
    chk_int("midreset_acc", acc_count, 0);
    chk_int("midreset_oob", oob_count, 0);
    chk_real("midreset_mean", mean_err, 0.0, 0.0);
    chk_real("midreset_max", max_out, 0.0, 0.0);
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_noise_stats_monitor
`default_nettype wire
